// File: rtl/logic_op_pkg.sv
// Shared encodings for the LogicOp arbiter and its client blocks.
// Holds the operation codes, the FSM state type and the fixed LogicOp width.
package logic_op_pkg;

    localparam int LOGIC_W = 4;

    localparam logic [1:0] OP_NOT = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_arbiter_if.sv
// One requester channel: a valid/ready request carrying operands and an op code,
// and a valid/ready response carrying the result. master = client, slave = arbiter.
interface logic_op_arbiter_if;
    import logic_op_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [LOGIC_W-1:0] req_a;
    logic [LOGIC_W-1:0] req_b;
    logic [1:0]         req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [LOGIC_W-1:0] rsp_data;
    logic               rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/logic_op_arbiter_logic_op.sv
// LogicOp unit: logical NOT/AND/OR of two 4-bit operands, each result a 0/1 flag
// in bit 0 of a 4-bit word.
module logic_op_arbiter_logic_op (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic [3:0] res1,
    output logic [3:0] res2,
    output logic [3:0] res3
);

    assign res1 = {3'b000, (in1 == 4'd0)};
    assign res2 = {3'b000, ((in1 != 4'd0) && (in2 != 4'd0))};
    assign res3 = {3'b000, ((in1 != 4'd0) || (in2 != 4'd0))};

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one LogicOp unit between two requesters, one op in flight.
//   state | meaning
//   IDLE  | waiting for a request; grant offered combinationally
//   EXEC  | latched operands drive LogicOp; result is registered
//   RESP  | rsp_valid to the tagged requester until it takes the result
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int DATA_W  = LOGIC_W,
    parameter bit RR_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_op_arbiter_if.slave  port0,
    logic_op_arbiter_if.slave  port1,
    output logic               busy
);

    state_t state, state_nxt;

    logic              ptr;
    logic              tag;
    logic              winner;
    logic              accept;
    logic              rsp_hs;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [3:0]        res1, res2, res3;
    logic [DATA_W-1:0] result;
    logic              result_err;

    // Contention goes to ptr; a lone requester wins outright.
    always_comb begin
        if (port0.req_valid && port1.req_valid) winner = ptr;
        else                                    winner = port1.req_valid;
    end

    assign accept = rst_n && (state == IDLE) && (port0.req_valid || port1.req_valid);
    assign rsp_hs = (state == RESP) && (tag ? port1.rsp_ready : port0.rsp_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy            = (state == EXEC) || (state == RESP);
        port0.req_ready = accept && !winner;
        port1.req_ready = accept && winner;
        port0.rsp_valid = (state == RESP) && !tag;
        port1.rsp_valid = (state == RESP) && tag;
        port0.rsp_data  = tag ? '0 : data_q;
        port1.rsp_data  = tag ? data_q : '0;
        port0.rsp_err   = !tag && err_q;
        port1.rsp_err   = tag && err_q;
    end

    logic_op_arbiter_logic_op u_logic_op (
        .in1  (a_q),
        .in2  (b_q),
        .res1 (res1),
        .res2 (res2),
        .res3 (res3)
    );

    always_comb begin
        result     = '0;
        result_err = 1'b0;
        unique case (op_q)
            OP_NOT:  result = res1;
            OP_AND:  result = res2;
            OP_OR:   result = res3;
            default: result_err = 1'b1;
        endcase
    end

    // data/err are zero outside RESP, so the unselected port always reads zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= RR_INIT;
            tag    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_NOT;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= winner ? port1.req_a  : port0.req_a;
                b_q  <= winner ? port1.req_b  : port0.req_b;
                op_q <= winner ? port1.req_op : port0.req_op;
                tag  <= winner;
                ptr  <= !winner;
            end
            if (state == EXEC) begin
                data_q <= result;
                err_q  <= result_err;
            end else if (rsp_hs) begin
                data_q <= '0;
                err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Bench for logic_op_arbiter: transaction-level model checked every cycle plus
// directed operations with hand-computed results.
module tb_logic_op_arbiter;
    import logic_op_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    logic_op_arbiter_if p0();
    logic_op_arbiter_if p1();

    logic_op_arbiter #(.DATA_W(4), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .port0 (p0),
        .port1 (p1),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void eval(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                 output logic [3:0] d, output logic e);
        e = 1'b0;
        case (op)
            2'd0:    d = (a == 0) ? 4'd1 : 4'd0;
            2'd1:    d = (a != 0 && b != 0) ? 4'd1 : 4'd0;
            2'd2:    d = (a != 0 || b != 0) ? 4'd1 : 4'd0;
            default: begin d = 4'd0; e = 1'b1; end
        endcase
    endfunction

    // Model: one op in flight; result offered two cycles after the grant cycle.
    bit         m_busy = 1'b0;
    int         m_age  = 0;
    bit         m_tag  = 1'b0;
    bit         m_ptr  = 1'b0;
    logic [3:0] m_data = 4'd0;
    logic       m_err  = 1'b0;

    always @(negedge clk) begin
        bit w, er0, er1, ev0, ev1, rr;
        logic [3:0] d;
        logic e;
        w   = (p0.req_valid && p1.req_valid) ? m_ptr : p1.req_valid;
        er0 = rst_n && !m_busy && p0.req_valid && !w;
        er1 = rst_n && !m_busy && p1.req_valid && w;
        ev0 = m_busy && m_age >= 2 && !m_tag;
        ev1 = m_busy && m_age >= 2 && m_tag;
        if (chk_en) begin
            chk("req0_ready", p0.req_ready, er0);
            chk("req1_ready", p1.req_ready, er1);
            chk("rsp0_valid", p0.rsp_valid, ev0);
            chk("rsp1_valid", p1.rsp_valid, ev1);
            chk("rsp0_data",  p0.rsp_data, ev0 ? m_data : 4'd0);
            chk("rsp1_data",  p1.rsp_data, ev1 ? m_data : 4'd0);
            chk("rsp0_err",   p0.rsp_err, ev0 ? m_err : 1'b0);
            chk("rsp1_err",   p1.rsp_err, ev1 ? m_err : 1'b0);
            chk("busy",       busy, m_busy);
        end
        rr = m_tag ? p1.rsp_ready : p0.rsp_ready;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 2 && rr) m_busy = 1'b0;
            else                  m_age++;
        end else if (p0.req_valid || p1.req_valid) begin
            if (w) eval(p1.req_op, p1.req_a, p1.req_b, d, e);
            else   eval(p0.req_op, p0.req_a, p0.req_b, d, e);
            m_data = d;
            m_err  = e;
            m_tag  = w;
            m_ptr  = !w;
            m_busy = 1'b1;
            m_age  = 1;
        end
    end

    function automatic logic rdy(input int n);
        return (n == 0) ? p0.req_ready : p1.req_ready;
    endfunction
    function automatic logic rv(input int n);
        return (n == 0) ? p0.rsp_valid : p1.rsp_valid;
    endfunction
    function automatic logic [3:0] rdat(input int n);
        return (n == 0) ? p0.rsp_data : p1.rsp_data;
    endfunction
    function automatic logic rerr(input int n);
        return (n == 0) ? p0.rsp_err : p1.rsp_err;
    endfunction

    task automatic set_req(input int n, input logic v, input logic [3:0] a,
                           input logic [3:0] b, input logic [1:0] op);
        if (n == 0) begin p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_op = op; end
        else        begin p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_op = op; end
    endtask

    // Issue one op, check the literal result; returns cycles from grant to rsp_valid.
    task automatic do_op(input int n, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                         input logic [3:0] xd, input logic xe, input string nm, output int lat);
        bit got;
        set_req(n, 1'b1, a, b, op);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rdy(n)) got = 1'b1;
        end
        chk({nm, "_granted"}, got, 1'b1);
        @(posedge clk); #1;
        set_req(n, 1'b0, a, b, op);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (rv(n)) got = 1'b1;
        end
        chk({nm, "_rsp_seen"}, got, 1'b1);
        chk({nm, "_data"}, rdat(n), xd);
        chk({nm, "_err"}, rerr(n), xe);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c0, c1, cyc;
        int glog[$];
        int gcyc[$];
        bit done;

        rst_n = 1'b0;
        set_req(0, 1'b0, 4'd0, 4'd0, 2'd0);
        set_req(1, 1'b0, 4'd0, 4'd0, 2'd0);
        p0.rsp_ready = 1'b1;
        p1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rsp0_valid", p0.rsp_valid, 1'b0);
        chk("reset_rsp1_valid", p1.rsp_valid, 1'b0);
        @(posedge clk); #1;

        // 1: AND of two nonzero operands
        do_op(0, 4'b1010, 4'b0101, OP_AND, 4'b0001, 1'b0, "t1_and", lat);
        chk("t1_latency", lat, 2);

        // 2: NOT of zero, then of nonzero
        do_op(1, 4'b0000, 4'b0000, OP_NOT, 4'b0001, 1'b0, "t2_not0", lat);
        do_op(1, 4'b0110, 4'b0000, OP_NOT, 4'b0000, 1'b0, "t2_not6", lat);

        // 3: contention from reset priority, four ops each
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 1'b1, 4'b0000, 4'b0000, OP_OR);
        set_req(1, 1'b1, 4'b0001, 4'b1000, OP_OR);
        c0 = 0; c1 = 0; cyc = 0; done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (p0.req_valid && p0.req_ready) begin c0++; glog.push_back(0); gcyc.push_back(cyc); end
            if (p1.req_valid && p1.req_ready) begin c1++; glog.push_back(1); gcyc.push_back(cyc); end
            @(posedge clk); #1;
            if (c0 == 4) p0.req_valid = 1'b0;
            if (c1 == 4) p1.req_valid = 1'b0;
            done = (c0 == 4) && (c1 == 4);
        end
        chk("t3_grant_count", glog.size(), 8);
        for (int i = 0; i < glog.size() && i < 8; i++) begin
            chk($sformatf("t3_grant%0d", i), glog[i], i % 2);
            if (i > 0) chk($sformatf("t3_spacing%0d", i), gcyc[i] - gcyc[i-1], 3);
        end
        repeat (3) @(posedge clk);
        #1;

        // 4: stalled response held stable
        p0.rsp_ready = 1'b0;
        do_op(0, 4'b1111, 4'b0001, OP_AND, 4'b0001, 1'b0, "t4_and", lat);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", p0.rsp_valid, 1'b1);
            chk("t4_hold_data", p0.rsp_data, 4'b0001);
            chk("t4_hold_busy", busy, 1'b1);
        end
        @(posedge clk); #1;
        p0.rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_idle_after_release", busy, 1'b0);
        chk("t4_data_cleared", p0.rsp_data, 4'b0000);
        @(posedge clk); #1;

        // 5: illegal op
        do_op(0, 4'b1111, 4'b1111, OP_ILL, 4'b0000, 1'b1, "t5_ill", lat);

        // 6: reset while an op executes
        set_req(0, 1'b1, 4'b0001, 4'b0001, OP_AND);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (p0.req_ready) done = 1'b1;
        end
        chk("t6_granted", done, 1'b1);
        @(posedge clk); #1;
        p0.req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_busy_cleared", busy, 1'b0);
        chk("t6_rsp0_valid", p0.rsp_valid, 1'b0);
        chk("t6_rsp0_data", p0.rsp_data, 4'b0000);
        repeat (4) begin
            @(negedge clk);
            chk("t6_no_response", p0.rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        do_op(1, 4'b0001, 4'b0000, OP_OR, 4'b0001, 1'b0, "t6_or", lat);

        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
